// File: rtl/core_pipe_cf_arbiter_if.sv
// Redirect bus bundle between the three control-flow sources, the arbiter and fetch.
// The CORE_CF_ARB_STATS_EN macro adds the per-source handshake counters.
interface core_pipe_cf_arbiter_if #(
  parameter int ADDR_W = 39
);
  logic              trp_req;
  logic [ADDR_W-1:0] trp_target;
  logic              trp_ack;
  logic              irq_req;
  logic [ADDR_W-1:0] irq_target;
  logic              irq_ack;
  logic              exe_req;
  logic [ADDR_W-1:0] exe_target;
  logic              exe_ack;
  logic              cf_valid;
  logic              cf_ack;
  logic [ADDR_W-1:0] cf_target;
  logic              flush_fd;
  logic              flush_ex;
  logic              busy;
`ifdef CORE_CF_ARB_STATS_EN
  logic [31:0]       cnt_trp;
  logic [31:0]       cnt_irq;
  logic [31:0]       cnt_exe;
`endif

  modport slave (
    input  trp_req, trp_target, irq_req, irq_target, exe_req, exe_target, cf_ack,
`ifdef CORE_CF_ARB_STATS_EN
    output cnt_trp, cnt_irq, cnt_exe,
`endif
    output trp_ack, irq_ack, exe_ack, cf_valid, cf_target, flush_fd, flush_ex, busy
  );

  modport master (
    output trp_req, trp_target, irq_req, irq_target, exe_req, exe_target, cf_ack,
`ifdef CORE_CF_ARB_STATS_EN
    input  cnt_trp, cnt_irq, cnt_exe,
`endif
    input  trp_ack, irq_ack, exe_ack, cf_valid, cf_target, flush_fd, flush_ex, busy
  );
endinterface

// File: rtl/core_pipe_cf_arbiter.sv
// Fixed-priority (trp > irq > exe), non-preemptive redirect arbiter onto the fetch bus.
// Optional per-source handshake counters under CORE_CF_ARB_STATS_EN.
module core_pipe_cf_arbiter #(
  parameter int ADDR_W = 39
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  core_pipe_cf_arbiter_if.slave  cf
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        src_q, src_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [2:0]        req_v, req_m, grant;
  logic              ack_cyc, arb_en;

  always_comb begin
    req_v   = {cf.trp_req, cf.irq_req, cf.exe_req};
    ack_cyc = (state_q == ST_HOLD) && cf.cf_ack;
    arb_en  = (state_q == ST_IDLE) || ack_cyc;
    // The acked source may still show req this cycle; keep it out of the re-arbitration.
    req_m   = req_v & ~(ack_cyc ? src_q : 3'b000);
    grant   = 3'b000;
    if (arb_en) begin
      if (req_m[2])      grant = 3'b100;
      else if (req_m[1]) grant = 3'b010;
      else if (req_m[0]) grant = 3'b001;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    tgt_d   = tgt_q;
    if (|grant) begin
      state_d = ST_HOLD;
      src_d   = grant;
      if (grant[2])      tgt_d = cf.trp_target;
      else if (grant[1]) tgt_d = cf.irq_target;
      else               tgt_d = cf.exe_target;
    end else if (ack_cyc) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      src_q   <= 3'b000;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      tgt_q   <= tgt_d;
    end
  end

  assign cf.cf_valid  = (state_q == ST_HOLD);
  assign cf.busy      = (state_q == ST_HOLD);
  assign cf.cf_target = tgt_q;
  assign cf.trp_ack   = ack_cyc & src_q[2];
  assign cf.irq_ack   = ack_cyc & src_q[1];
  assign cf.exe_ack   = ack_cyc & src_q[0];
  assign cf.flush_fd  = |grant;
  assign cf.flush_ex  = grant[2] | grant[1];

`ifdef CORE_CF_ARB_STATS_EN
  logic [31:0] cnt_trp_q, cnt_irq_q, cnt_exe_q;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      cnt_trp_q <= '0;
      cnt_irq_q <= '0;
      cnt_exe_q <= '0;
    end else begin
      if (cf.trp_ack && (cnt_trp_q != 32'hFFFF_FFFF)) cnt_trp_q <= cnt_trp_q + 32'd1;
      if (cf.irq_ack && (cnt_irq_q != 32'hFFFF_FFFF)) cnt_irq_q <= cnt_irq_q + 32'd1;
      if (cf.exe_ack && (cnt_exe_q != 32'hFFFF_FFFF)) cnt_exe_q <= cnt_exe_q + 32'd1;
    end
  end

  assign cf.cnt_trp = cnt_trp_q;
  assign cf.cnt_irq = cnt_irq_q;
  assign cf.cnt_exe = cnt_exe_q;
`endif
endmodule

// File: tb/tb_core_pipe_cf_arbiter.sv
// Scoreboard bench for the redirect arbiter: expected grants are queued when requests are driven
// and popped on each fetch handshake.
module tb_core_pipe_cf_arbiter;
  localparam int ADDR_W = 39;

  typedef struct {
    logic [2:0]        src;
    logic [ADDR_W-1:0] tgt;
  } sb_t;

  logic g_clk;
  logic g_reset;
  core_pipe_cf_arbiter_if #(.ADDR_W(ADDR_W)) cf ();

  core_pipe_cf_arbiter #(.ADDR_W(ADDR_W)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .cf      (cf.slave)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  sb_t   sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_val  = 0;
  int    n_ffd  = 0;
  int    n_fex  = 0;
  logic [31:0] m_trp = 0, m_irq = 0, m_exe = 0;

  always @(negedge g_clk) begin
    if (cf.cf_valid) n_val++;
    if (cf.flush_fd) n_ffd++;
    if (cf.flush_ex) n_fex++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", tag, act, exp);
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic push(input logic [2:0] src, input logic [ADDR_W-1:0] tgt);
    sb_t e;
    e.src = src;
    e.tgt = tgt;
    sb.push_back(e);
  endtask

  // Checks the current cycle; on a handshake pops the expected grant and retires that request.
  task automatic sample();
    sb_t  e;
    logic [2:0] acks;
    acks = {cf.trp_ack, cf.irq_ack, cf.exe_ack};
    if (cf.cf_valid && cf.cf_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_handshake", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ack_vec", acks, e.src);
        chk("ack_tgt", cf.cf_target, e.tgt);
        if (e.src[2]) begin cf.trp_req = 1'b0; m_trp = sat_inc(m_trp); end
        if (e.src[1]) begin cf.irq_req = 1'b0; m_irq = sat_inc(m_irq); end
        if (e.src[0]) begin cf.exe_req = 1'b0; m_exe = sat_inc(m_exe); end
      end
    end else begin
      chk("ack_idle", acks, 3'b000);
      if (cf.cf_valid && sb.size() > 0) chk("hold_tgt", cf.cf_target, sb[0].tgt);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
    sample();
  endtask

  task automatic run_until_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !cf.cf_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  int b_val, b_ffd, b_fex;

  initial begin
    g_reset       = 1'b1;
    cf.trp_req    = 1'b0; cf.trp_target = '0;
    cf.irq_req    = 1'b0; cf.irq_target = '0;
    cf.exe_req    = 1'b0; cf.exe_target = '0;
    cf.cf_ack     = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_valid",  cf.cf_valid, 0);
    chk("rst_target", cf.cf_target, 0);
    chk("rst_acks",   {cf.trp_ack, cf.irq_ack, cf.exe_ack}, 0);
    chk("rst_flush",  {cf.flush_fd, cf.flush_ex}, 0);
    chk("rst_busy",   cf.busy, 0);
    g_reset = 1'b0;
    tick();

    // Single exe redirect with fetch always accepting.
    cf.exe_req = 1'b1; cf.exe_target = 39'h1000; cf.cf_ack = 1'b1;
    push(3'b001, 39'h1000);
    #1;
    chk("t1_flush_fd", cf.flush_fd, 1);
    chk("t1_flush_ex", cf.flush_ex, 0);
    chk("t1_valid_t0", cf.cf_valid, 0);
    tick();
    chk("t1_valid_t1", cf.cf_valid, 1);
    tick();
    chk("t1_idle_t2", {cf.cf_valid, cf.busy}, 2'b00);

    // All three at once: back-to-back in priority order.
    b_val = n_val; b_fex = n_fex; b_ffd = n_ffd;
    cf.trp_req = 1'b1; cf.trp_target = 39'h80;
    cf.irq_req = 1'b1; cf.irq_target = 39'h40;
    cf.exe_req = 1'b1; cf.exe_target = 39'h2000;
    push(3'b100, 39'h80); push(3'b010, 39'h40); push(3'b001, 39'h2000);
    #1;
    chk("t2_grant_flush_ex", cf.flush_ex, 1);
    tick(); tick(); tick();
    tick();
    chk("t2_idle", cf.cf_valid, 0);
    chk("t2_valid_cycles", n_val - b_val, 3);
    chk("t2_flush_ex_cnt", n_fex - b_fex, 2);
    chk("t2_flush_fd_cnt", n_ffd - b_ffd, 3);
    chk("t2_sb_empty", sb.size(), 0);

    // Held exe is not preempted by a later trp.
    cf.cf_ack = 1'b0;
    cf.exe_req = 1'b1; cf.exe_target = 39'h1000;
    push(3'b001, 39'h1000);
    tick(); tick();
    cf.trp_req = 1'b1; cf.trp_target = 39'h80;
    push(3'b100, 39'h80);
    #1;
    chk("t3_no_flush_in_hold", cf.flush_fd, 0);
    tick(); tick(); tick();
    chk("t3_still_exe", cf.cf_target, 39'h1000);
    cf.cf_ack = 1'b1;
    #1;
    sample();
    tick();
    chk("t3_next_trp", cf.cf_target, 39'h80);
    run_until_idle(10);

    // Withdrawn exe still completes.
    cf.cf_ack = 1'b0;
    cf.exe_req = 1'b1; cf.exe_target = 39'h1234;
    push(3'b001, 39'h1234);
    tick(); tick();
    cf.exe_req = 1'b0;
    tick();
    chk("t4_valid_kept", cf.cf_valid, 1);
    tick();
    cf.cf_ack = 1'b1;
    #1;
    chk("t4_exe_ack", cf.exe_ack, 1);
    sample();
    tick();
    chk("t4_idle", cf.cf_valid, 0);

    // Reset in HOLD drops the redirect; pending trp granted afterwards.
    cf.cf_ack = 1'b0;
    cf.exe_req = 1'b1; cf.exe_target = 39'h1000;
    push(3'b001, 39'h1000);
    tick(); tick();
    cf.trp_req = 1'b1; cf.trp_target = 39'h80;
    #2;
    g_reset = 1'b1;
    #1;
    chk("t5_valid_async", cf.cf_valid, 0);
    chk("t5_acks", {cf.trp_ack, cf.irq_ack, cf.exe_ack}, 0);
    sb.delete();
    cf.exe_req = 1'b0;
    m_trp = 0; m_irq = 0; m_exe = 0;
    @(posedge g_clk); #1;
    chk("t5_in_reset", {cf.cf_valid, cf.busy}, 2'b00);
    g_reset = 1'b0;
    push(3'b100, 39'h80);
    #1;
    chk("t5_trp_flush_ex", cf.flush_ex, 1);
    cf.cf_ack = 1'b1;
    run_until_idle(10);

`ifdef CORE_CF_ARB_STATS_EN
    for (int i = 0; i < 3; i++) begin
      cf.exe_req = 1'b1; cf.exe_target = 39'h3000 + 39'(i);
      push(3'b001, 39'h3000 + 39'(i));
      run_until_idle(10);
    end
    tick();
    chk("cnt_exe", cf.cnt_exe, m_exe);
    chk("cnt_trp", cf.cnt_trp, m_trp);
    chk("cnt_irq", cf.cnt_irq, m_irq);
    chk("cnt_exe_3", cf.cnt_exe, 3);
    force dut.cnt_exe_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_exe_q;
    m_exe = 32'hFFFF_FFFF;
    cf.exe_req = 1'b1; cf.exe_target = 39'h4000;
    push(3'b001, 39'h4000);
    run_until_idle(10);
    tick();
    chk("cnt_exe_sat", cf.cnt_exe, m_exe);
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
